axi_write_initiator: RTL and testbench

AXI_WRITE_INITIATOR -- requirements
Module: axi_write_initiator

---
 rtl/axi_pkg.sv | 28 ++
 rtl/axi_write_initiator_if.sv | 41 ++++
 rtl/sync_fifo.sv | 59 +++++
 rtl/axi_write_initiator.sv | 144 ++++++++++++++
 tb/tb_axi_write_initiator.sv | 331 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi_pkg.sv
// Shared types and AXI encodings for the single-burst AXI write initiator.
package axi_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned LEN_W  = 4;
    localparam int unsigned ID_W   = 8;
    localparam int unsigned CNT_W  = 5;

    localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
    localparam logic [3:0] AXI_STRB_ALL   = 4'hF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        RESP = 2'd3
    } axi_state_e;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [LEN_W-1:0]  len;
        logic [ID_W-1:0]   id;
    } wr_req_t;

endpackage

// File: rtl/axi_write_initiator_if.sv
// AXI write channels (AW, W, B) between the initiator and a write target.
interface axi_write_initiator_if;

    logic [axi_pkg::ID_W-1:0]   AWID;
    logic [axi_pkg::ADDR_W-1:0] AWADDR;
    logic [axi_pkg::LEN_W-1:0]  AWLEN;
    logic [2:0]                 AWSIZE;
    logic [1:0]                 AWBURST;
    logic                       AWVALID;
    logic                       AWREADY;

    logic [axi_pkg::DATA_W-1:0] WDATA;
    logic [3:0]                 WSTRB;
    logic                       WLAST;
    logic                       WVALID;
    logic                       WREADY;

    logic [axi_pkg::ID_W-1:0]   BID;
    logic [1:0]                 BRESP;
    logic                       BVALID;
    logic                       BREADY;

    modport master (
        output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
        input  AWREADY,
        output WDATA, WSTRB, WLAST, WVALID,
        input  WREADY,
        input  BID, BRESP, BVALID,
        output BREADY
    );

    modport slave (
        input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
        output AWREADY,
        input  WDATA, WSTRB, WLAST, WVALID,
        output WREADY,
        output BID, BRESP, BVALID,
        input  BREADY
    );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a 5-bit occupancy count; full/empty decode from the count register.
module sync_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [WIDTH-1:0] rdata_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = 5;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             push_en;
    logic             pop_en;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign push_en = push_i && !full_o;
    assign pop_en  = pop_i && !empty_o;
    assign rdata_o = mem_q[rd_ptr_q];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_en) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_en) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({push_en, pop_en})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_en) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/axi_write_initiator.sv
// Issues one INCR AXI write burst per request, streaming beats from a local data FIFO.
module axi_write_initiator
    import axi_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                  ACLK,
    input  logic                  ARESET,

    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [LEN_W-1:0]      req_len,
    input  logic [ID_W-1:0]       req_id,

    input  logic                  din_valid,
    output logic                  din_ready,
    input  logic [DATA_W-1:0]     din_data,

    axi_write_initiator_if.master axi,

    output logic                  done,
    output logic [1:0]            done_resp,
    output logic                  err
);

    axi_state_e        state_q;
    axi_state_e        state_d;
    wr_req_t           req_q;
    logic [LEN_W-1:0]  beat_q;
    logic              done_q;
    logic [1:0]        done_resp_q;
    logic              err_q;

    logic              fifo_full;
    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_head;
    logic              w_hs;
    logic              last_beat;

    assign w_hs      = (state_q == DATA) && !fifo_empty && axi.WREADY;
    assign last_beat = (beat_q == req_q.len);
    assign din_ready = !fifo_full;
    assign done      = done_q;
    assign done_resp = done_resp_q;
    assign err       = err_q;

    sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (ACLK),
        .rst_i   (ARESET),
        .push_i  (din_valid),
        .wdata_i (din_data),
        .pop_i   (w_hs),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .rdata_o (fifo_head)
    );

    // Next-state and channel outputs; payloads are zero outside their owning state.
    always_comb begin
        state_d     = state_q;
        req_ready   = 1'b0;
        axi.AWVALID = 1'b0;
        axi.AWID    = '0;
        axi.AWADDR  = '0;
        axi.AWLEN   = '0;
        axi.AWSIZE  = '0;
        axi.AWBURST = '0;
        axi.WVALID  = 1'b0;
        axi.WDATA   = '0;
        axi.WSTRB   = '0;
        axi.WLAST   = 1'b0;
        axi.BREADY  = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_d = ADDR;
                end
            end
            ADDR: begin
                axi.AWVALID = 1'b1;
                axi.AWID    = req_q.id;
                axi.AWADDR  = req_q.addr & ~ADDR_W'(3);
                axi.AWLEN   = req_q.len;
                axi.AWSIZE  = AXI_SIZE_4B;
                axi.AWBURST = AXI_BURST_INCR;
                if (axi.AWREADY) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                axi.WVALID = !fifo_empty;
                axi.WDATA  = fifo_empty ? '0 : fifo_head;
                axi.WSTRB  = AXI_STRB_ALL;
                axi.WLAST  = !fifo_empty && last_beat;
                if (w_hs && last_beat) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                axi.BREADY = 1'b1;
                if (axi.BVALID) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q     <= IDLE;
            req_q       <= '0;
            beat_q      <= '0;
            done_q      <= 1'b0;
            done_resp_q <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= 1'b0;
            if (state_q == IDLE && req_valid) begin
                req_q <= '{addr: req_addr, len: req_len, id: req_id};
            end
            if (state_q == ADDR && axi.AWREADY) begin
                beat_q <= '0;
            end else if (w_hs) begin
                beat_q <= beat_q + LEN_W'(1);
            end
            // Completion status; err is sticky until reset.
            if (state_q == RESP && axi.BVALID) begin
                done_q      <= 1'b1;
                done_resp_q <= axi.BRESP;
                if (axi.BRESP != AXI_RESP_OKAY || axi.BID != req_q.id) begin
                    err_q <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_axi_write_initiator.sv
// Self-checking bench: scoreboard of pushed words checked against W beats, plus AW/B/status checks.
module tb_axi_write_initiator;

    localparam int unsigned DEPTH = 16;

    logic        ACLK = 1'b0;
    logic        ARESET;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [3:0]  req_len;
    logic [7:0]  req_id;
    logic        din_valid;
    logic        din_ready;
    logic [31:0] din_data;
    logic        done;
    logic [1:0]  done_resp;
    logic        err;

    axi_write_initiator_if axi();

    axi_write_initiator #(.FIFO_DEPTH(DEPTH)) dut (
        .ACLK      (ACLK),
        .ARESET    (ARESET),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_len   (req_len),
        .req_id    (req_id),
        .din_valid (din_valid),
        .din_ready (din_ready),
        .din_data  (din_data),
        .axi       (axi),
        .done      (done),
        .done_resp (done_resp),
        .err       (err)
    );

    always #5 ACLK = ~ACLK;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    logic [31:0] exp_q[$];
    bit          aw_seen    = 1'b0;
    int          mon_len    = 0;
    int          mon_beat   = 0;
    int          beat_total = 0;
    int          last_total = 0;
    int          done_cnt   = 0;
    bit          prev_done  = 1'b0;
    bit          stall_prev = 1'b0;
    logic [31:0] stall_data = '0;
    logic [31:0] exp_awaddr = '0;
    logic [3:0]  exp_awlen  = '0;
    logic [7:0]  exp_awid   = '0;
    logic [1:0]  exp_resp   = '0;
    bit          exp_err    = 1'b0;
    bit          wr_toggle  = 1'b0;

    initial begin
        axi.WREADY = 1'b1;
        forever begin
            @(posedge ACLK);
            #1;
            axi.WREADY = wr_toggle ? ~axi.WREADY : 1'b1;
        end
    end

    // Channel monitor, sampled on the falling edge.
    always @(negedge ACLK) begin
        if (!ARESET) begin
            check("w_before_aw", 32'(axi.WVALID && !aw_seen), 32'd0);
            if (stall_prev) begin
                check("wvalid_hold", 32'(axi.WVALID), 32'd1);
                check("wdata_hold", axi.WDATA, stall_data);
            end
            stall_prev = axi.WVALID && !axi.WREADY;
            stall_data = axi.WDATA;
            if (axi.AWVALID && axi.AWREADY) begin
                check("awaddr", axi.AWADDR, exp_awaddr);
                check("awlen", 32'(axi.AWLEN), 32'(exp_awlen));
                check("awid", 32'(axi.AWID), 32'(exp_awid));
                check("awsize", 32'(axi.AWSIZE), 32'd2);
                check("awburst", 32'(axi.AWBURST), 32'd1);
                aw_seen  = 1'b1;
                mon_beat = 0;
            end
            if (axi.WVALID && axi.WREADY) begin
                if (exp_q.size() == 0) begin
                    check("w_unexpected", 32'd1, 32'd0);
                end else begin
                    check("wdata", axi.WDATA, exp_q.pop_front());
                end
                check("wlast", 32'(axi.WLAST), 32'(mon_beat == mon_len));
                check("wstrb", 32'(axi.WSTRB), 32'hF);
                if (axi.WLAST) last_total++;
                mon_beat++;
                beat_total++;
            end
            if (axi.BVALID && axi.BREADY) aw_seen = 1'b0;
            if (done) begin
                check("done_width", 32'(prev_done), 32'd0);
                check("done_resp", 32'(done_resp), 32'(exp_resp));
                check("err", 32'(err), 32'(exp_err));
                done_cnt++;
            end
            prev_done = done;
        end else begin
            prev_done  = 1'b0;
            stall_prev = 1'b0;
        end
    end

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic do_reset();
        ARESET = 1'b1;
        tick();
        tick();
        exp_q.delete();
        aw_seen  = 1'b0;
        mon_beat = 0;
        exp_err  = 1'b0;
        ARESET   = 1'b0;
    endtask

    task automatic push(input logic [31:0] d, output bit acc);
        din_valid = 1'b1;
        din_data  = d;
        acc       = din_ready;
        if (acc) exp_q.push_back(d);
        tick();
        din_valid = 1'b0;
    endtask

    task automatic issue(input logic [31:0] a, input logic [3:0] l, input logic [7:0] id);
        int n = 0;
        while (!req_ready && n < 100) begin
            tick();
            n++;
        end
        check("req_ready_wait", 32'(req_ready), 32'd1);
        mon_len    = int'(l);
        exp_awaddr = a & 32'hFFFF_FFFC;
        exp_awlen  = l;
        exp_awid   = id;
        exp_resp   = axi.BRESP;
        exp_err    = exp_err | (axi.BRESP != 2'b00) | (axi.BID != id);
        req_valid  = 1'b1;
        req_addr   = a;
        req_len    = l;
        req_id     = id;
        tick();
        req_valid  = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int start = done_cnt;
        int n = 0;
        while (done_cnt == start && n < 400) begin
            tick();
            n++;
        end
        check({tag, "_done"}, 32'(done_cnt - start), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc;
        int b0, l0, n_acc, d0, n;

        ARESET = 1'b1; req_valid = 1'b0; req_addr = '0; req_len = '0; req_id = '0;
        din_valid = 1'b0; din_data = '0;
        axi.AWREADY = 1'b1; axi.BVALID = 1'b1; axi.BID = 8'h03; axi.BRESP = 2'b00;
        do_reset();

        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_din_ready", 32'(din_ready), 32'd1);
        check("rst_awvalid", 32'(axi.AWVALID), 32'd0);
        check("rst_wvalid", 32'(axi.WVALID), 32'd0);
        check("rst_wlast", 32'(axi.WLAST), 32'd0);
        check("rst_bready", 32'(axi.BREADY), 32'd0);
        check("rst_awaddr", axi.AWADDR, 32'd0);
        check("rst_awlen", 32'(axi.AWLEN), 32'd0);
        check("rst_awid", 32'(axi.AWID), 32'd0);
        check("rst_awsize", 32'(axi.AWSIZE), 32'd0);
        check("rst_awburst", 32'(axi.AWBURST), 32'd0);
        check("rst_wdata", axi.WDATA, 32'd0);
        check("rst_wstrb", 32'(axi.WSTRB), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_done_resp", 32'(done_resp), 32'd0);
        check("rst_err", 32'(err), 32'd0);

        // Single beat
        b0 = beat_total; l0 = last_total;
        push(32'hA5A5_0001, acc);
        issue(32'h1000_0004, 4'd0, 8'h03);
        wait_done("single");
        check("single_beats", 32'(beat_total - b0), 32'd1);
        check("single_last", 32'(last_total - l0), 32'd1);
        check("single_err", 32'(err), 32'd0);

        // 16-beat burst with toggling WREADY and an unaligned start address
        b0 = beat_total; l0 = last_total; n_acc = 0;
        for (int i = 0; i < 16; i++) begin
            push(32'(i), acc);
            n_acc += int'(acc);
        end
        check("burst_fill", 32'(n_acc), 32'd16);
        wr_toggle = 1'b1;
        axi.BID = 8'h05;
        issue(32'h0000_2003, 4'd15, 8'h05);
        wait_done("burst");
        wr_toggle = 1'b0;
        check("burst_beats", 32'(beat_total - b0), 32'd16);
        check("burst_last", 32'(last_total - l0), 32'd1);
        check("burst_sb_empty", 32'(exp_q.size()), 32'd0);
        check("burst_din_ready", 32'(din_ready), 32'd1);

        // Starved FIFO: one word every three cycles
        b0 = beat_total; l0 = last_total;
        axi.BID = 8'h09;
        issue(32'h0000_3000, 4'd3, 8'h09);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("starve_empty_wvalid", 32'(axi.WVALID), 32'd0);
        end
        for (int k = 0; k < 4; k++) begin
            push(32'hC0DE_0000 + 32'(k), acc);
            tick();
            check("starve_gap1", 32'(axi.WVALID), 32'd0);
            tick();
            check("starve_gap2", 32'(axi.WVALID), 32'd0);
        end
        wait_done("starve");
        check("starve_beats", 32'(beat_total - b0), 32'd4);
        check("starve_last", 32'(last_total - l0), 32'd1);

        // AW backpressure
        b0 = beat_total;
        axi.AWREADY = 1'b0;
        axi.BID = 8'h03;
        push(32'hDEAD_0000, acc);
        push(32'hDEAD_0001, acc);
        issue(32'h4000_0010, 4'd1, 8'h03);
        for (int i = 0; i < 5; i++) begin
            check("bp_awvalid", 32'(axi.AWVALID), 32'd1);
            check("bp_awaddr", axi.AWADDR, 32'h4000_0010);
            check("bp_awlen", 32'(axi.AWLEN), 32'd1);
            check("bp_awid", 32'(axi.AWID), 32'h03);
            check("bp_wvalid", 32'(axi.WVALID), 32'd0);
            check("bp_req_ready", 32'(req_ready), 32'd0);
            tick();
        end
        axi.AWREADY = 1'b1;
        wait_done("bp");
        check("bp_beats", 32'(beat_total - b0), 32'd2);

        // Error responses and sticky err
        axi.BRESP = 2'b10; axi.BID = 8'h03;
        push(32'hBAD0_0001, acc);
        issue(32'h0000_5000, 4'd0, 8'h03);
        wait_done("slverr");
        check("slverr_resp", 32'(done_resp), 32'h2);
        check("slverr_err", 32'(err), 32'd1);
        axi.BRESP = 2'b00; axi.BID = 8'h07;
        push(32'hBAD0_0002, acc);
        issue(32'h0000_5100, 4'd0, 8'h03);
        wait_done("badid");
        check("badid_resp", 32'(done_resp), 32'h0);
        check("badid_err", 32'(err), 32'd1);
        axi.BID = 8'h03;
        push(32'h600D_0001, acc);
        issue(32'h0000_5200, 4'd0, 8'h03);
        wait_done("good");
        check("sticky_err", 32'(err), 32'd1);
        do_reset();
        check("err_cleared", 32'(err), 32'd0);
        check("resp_cleared", 32'(done_resp), 32'd0);

        // Overfill, then reset in the middle of a burst
        n_acc = 0;
        for (int i = 0; i < DEPTH + 1; i++) begin
            push(32'hE000_0000 + 32'(i), acc);
            n_acc += int'(acc);
            if (i == DEPTH - 1) check("full_din_ready", 32'(din_ready), 32'd0);
            if (i == DEPTH) check("full_reject", 32'(acc), 32'd0);
        end
        check("full_accepted", 32'(n_acc), 32'(DEPTH));
        axi.BID = 8'h01;
        b0 = beat_total;
        issue(32'h0000_6000, 4'd15, 8'h01);
        n = 0;
        while (beat_total - b0 < 3 && n < 100) begin
            tick();
            n++;
        end
        check("mid_reached_data", 32'(beat_total - b0 >= 3), 32'd1);
        d0 = done_cnt;
        do_reset();
        check("mid_wvalid", 32'(axi.WVALID), 32'd0);
        check("mid_awvalid", 32'(axi.AWVALID), 32'd0);
        check("mid_din_ready", 32'(din_ready), 32'd1);
        check("mid_req_ready", 32'(req_ready), 32'd1);
        for (int i = 0; i < 5; i++) tick();
        check("mid_no_done", 32'(done_cnt - d0), 32'd0);
        check("mid_wvalid_idle", 32'(axi.WVALID), 32'd0);
        check("mid_err", 32'(err), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
